// File: rtl/adder_arb_pkg.sv
// ----------------------------------------------------------------------------
// adder_arb_pkg
// Shared definitions for the adder_arbiter slice:
//   NUM_REQ_DEF / WIDTH_DEF : default requester count and operand width
//   req_idx_t               : requester index, wide enough for the 8-port max
//   out_state_t             : output register occupancy (EMPTY / FULL)
// ----------------------------------------------------------------------------
package adder_arb_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int WIDTH_DEF   = 32;
    localparam int IDX_W       = 3;    // covers the full 2..8 requester range

    typedef logic [IDX_W-1:0] req_idx_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/cla_32bit.sv
// ----------------------------------------------------------------------------
// cla_32bit
// 32-bit two-level carry-lookahead adder: 4-bit lookahead groups whose group
// generate/propagate terms form the carry into the next group.
// Ports:
//   a, b  in  32  operands
//   cin   in  1   carry-in
//   sum   out 32  a + b + cin modulo 2^32
//   cout  out 1   carry out of bit 31
// ----------------------------------------------------------------------------
module cla_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] g;
    logic [31:0] p;
    logic [7:0]  gg;
    logic [7:0]  pg;
    logic [32:0] c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        // NOTE: every signal written in a combinational block gets a default
        // first, so no path through the block can infer a latch.
        gg = '0;
        pg = '0;
        for (int j = 0; j < 8; j++) begin
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            pg[j] = &p[4*j +: 4];
        end
    end

    // Carries inside a group are fully expanded from the group carry-in;
    // the group carry-out uses the group generate/propagate pair.
    always_comb begin
        c    = '0;
        c[0] = cin;
        for (int j = 0; j < 8; j++) begin
            c[4*j+1] = g[4*j] | (p[4*j] & c[4*j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j])
                     | (p[4*j+1] & p[4*j] & c[4*j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
                     | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & c[4*j]);
            c[4*j+4] = gg[j] | (pg[j] & c[4*j]);
        end
    end

    assign sum  = p ^ c[31:0];
    assign cout = c[32];

endmodule

// File: rtl/adder_arbiter.sv
// ----------------------------------------------------------------------------
// adder_arbiter
// Round-robin arbiter time-sharing one 32-bit carry-lookahead adder among
// NUM_REQ requesters, with a single-entry registered result stage.
// Ports:
//   clk        in   1              rising-edge clock
//   rst        in   1              synchronous active-high reset
//   req_valid  in   NUM_REQ        per-requester operand valid
//   req_a      in   NUM_REQ*WIDTH  packed operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      in   NUM_REQ*WIDTH  packed operand B, same packing
//   req_ready  out  NUM_REQ        one-hot grant (or zero), combinational
//   res_valid  out  1              result register is FULL
//   res_ready  in   1              consumer takes the result
//   res_sum    out  WIDTH          registered sum
//   res_cout   out  1              registered carry-out
//   res_id     out  clog2(NUM_REQ) requester that produced the result
// Configuration macro:
//   ADDER_ARB_SAT_EN  when defined, a carry-out clamps res_sum to all ones.
// WIDTH must be 32: the shared adder is a fixed 32-bit instance.
// ----------------------------------------------------------------------------
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int WIDTH   = WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [WIDTH-1:0]           res_sum,
    output logic                       res_cout,
    output logic [$clog2(NUM_REQ)-1:0] res_id
);

    localparam int ID_W = $clog2(NUM_REQ);

    out_state_t       state;
    req_idx_t         last_grant;
    req_idx_t         grant_idx;
    logic             any_valid;
    logic             slot_open;
    logic             accept;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic [WIDTH-1:0] sum_final;

    // Round-robin pick: each valid requester gets a rank equal to its
    // distance after last_grant; the lowest rank wins. Depends only on
    // req_valid and last_grant, never on operand values.
    always_comb begin
        int rank;
        int best_rank;
        rank      = 0;
        best_rank = NUM_REQ;
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i]) begin
                rank = (i - int'(last_grant) - 1 + 2 * NUM_REQ) % NUM_REQ;
                if (rank < best_rank) begin
                    best_rank = rank;
                    grant_idx = req_idx_t'(i);
                end
            end
        end
    end

    assign any_valid = |req_valid;
    // A FULL register can drain and refill in the same cycle; reset closes it.
    assign slot_open = !rst && ((state == EMPTY) || res_ready);
    assign accept    = slot_open && any_valid;

    always_comb begin
        req_ready = '0;
        a_sel     = '0;
        b_sel     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == req_idx_t'(i)) begin
                req_ready[i] = accept;
                a_sel        = req_a[i*WIDTH +: WIDTH];
                b_sel        = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    cla_32bit u_cla (
        .a    (a_sel),
        .b    (b_sel),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

`ifdef ADDER_ARB_SAT_EN
    assign sum_final = add_cout ? '1 : add_sum;
`else
    assign sum_final = add_sum;
`endif

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: only control and the visible result are reset; the
            // operand path is purely combinational so nothing else holds state.
            state      <= EMPTY;
            res_sum    <= '0;
            res_cout   <= 1'b0;
            res_id     <= '0;
            last_grant <= req_idx_t'(NUM_REQ - 1);
        end else if (accept) begin
            state      <= FULL;
            res_sum    <= sum_final;
            res_cout   <= add_cout;
            res_id     <= grant_idx[ID_W-1:0];
            last_grant <= grant_idx;
        end else if ((state == FULL) && res_ready) begin
            state <= EMPTY;
        end
    end

    assign res_valid = (state == FULL);

endmodule
